// File: rtl/range_collector.sv
// rtl/range_collector.sv - captures range-finder results into a FIFO stream with error/drop counters
//
// Purpose:
//   Watches the range finder's go/finish control bus and captures each
//   completed measurement into a small result FIFO. The FIFO is presented
//   as a valid/ready stream. The block also keeps saturating counts of error
//   events and of results lost to a full FIFO.
//
// Optional feature macro: RANGE_COLLECT_MAX_EN (adds max_range output).
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset, clears all state
//   go          in   range finder go
//   finish      in   range finder finish
//   range       in   range finder result, sampled on the capture cycle
//   error       in   range finder error flag
//   out_data    out  FIFO head result
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accepts head
//   busy        out  measurement session in progress
//   err_count   out  saturating count of error rising edges
//   drop_count  out  saturating count of results dropped on a full FIFO
//   max_range   out  running maximum of captured ranges (RANGE_COLLECT_MAX_EN only)

module range_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             finish,
  input  logic [WIDTH-1:0] range,
  input  logic             error,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count
`ifdef RANGE_COLLECT_MAX_EN
  ,
  output logic [WIDTH-1:0] max_range
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_error_q;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_err_evt;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = (r_state == S_ACTIVE) && finish;
  assign w_pop     = !w_empty && out_ready;
  assign w_err_evt = error && !r_error_q;

  assign out_valid = !w_empty;
  // Head read straight from storage: stable while stalled because writes
  // never target the head slot unless that slot is popped in the same cycle.
  assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign busy      = (r_state == S_ACTIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_error_q  <= 1'b0;
      err_count  <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
`ifdef RANGE_COLLECT_MAX_EN
      max_range  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE:   if (go && !finish) r_state <= S_ACTIVE;
        S_ACTIVE: if (finish)        r_state <= S_HOLD;
        S_HOLD:   if (!finish)       r_state <= S_IDLE;
        default:                     r_state <= S_IDLE;
      endcase

      r_error_q <= error;
      if (w_err_evt && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end

      if (w_push) begin
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        if (!w_full || w_pop) begin
          r_mem[r_wr_ptr[AW-1:0]] <= range;
          r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
        end else if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end

`ifdef RANGE_COLLECT_MAX_EN
      // Dropped results still count toward the running maximum.
      if (w_push && (range > max_range)) begin
        max_range <= range;
      end
`endif
    end
  end

endmodule

// File: tb/tb_range_collector.sv
// tb/tb_range_collector.sv - randomized and directed self-checking bench for range_collector

module tb_range_collector;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range;
  logic             error;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] drop_count;
`ifdef RANGE_COLLECT_MAX_EN
  logic [WIDTH-1:0] max_range;
`endif

  range_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .finish     (finish),
    .range      (range),
    .error      (error),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_count  (err_count),
    .drop_count (drop_count)
`ifdef RANGE_COLLECT_MAX_EN
    ,
    .max_range  (max_range)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: session phase, result queue, counters.
  int               m_phase;   // 0 idle, 1 measuring, 2 waiting for finish to drop
  logic [WIDTH-1:0] m_q[$];
  int               m_ec;
  int               m_dc;
  int               m_max;
  logic             m_errq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_ec   = 0;
    m_dc   = 0;
    m_max  = 0;
    m_errq = 1'b0;
  endtask

  task automatic model_step(input logic g, input logic f, input logic [WIDTH-1:0] r,
                            input logic e, input logic rdy, input logic rs);
    bit was_full;
    bit pop;
    bit cap;
    if (rs) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    pop      = (m_q.size() != 0) && rdy;
    cap      = (m_phase == 1) && f;
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (was_full && !pop) begin
        if (m_dc < 255) m_dc++;
      end else begin
        m_q.push_back(r);
      end
      if (int'(r) > m_max) m_max = int'(r);
    end
    if (e && !m_errq && m_ec < 255) m_ec++;
    m_errq = e;
    if (m_phase == 0 && g && !f) m_phase = 1;
    else if (m_phase == 1 && f)  m_phase = 2;
    else if (m_phase == 2 && !f) m_phase = 0;
  endtask

  task automatic check_outputs();
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("data", 32'(out_data), 32'(m_q[0]));
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("err_count", 32'(err_count), 32'(m_ec));
    check("drop_count", 32'(drop_count), 32'(m_dc));
`ifdef RANGE_COLLECT_MAX_EN
    check("max_range", 32'(max_range), 32'(m_max));
`endif
  endtask

  // One clock cycle: drive, check registered outputs at negedge, advance model.
  task automatic step(input logic g, input logic f, input logic [WIDTH-1:0] r,
                      input logic e, input logic rdy, input logic rs);
    go = g; finish = f; range = r; error = e; out_ready = rdy; reset = rs;
    @(negedge clock);
    check_outputs();
    model_step(g, f, r, e, rdy, rs);
    @(posedge clock);
    #1;
  endtask

  task automatic session(input logic [WIDTH-1:0] r, input logic rdy);
    step(1'b1, 1'b0, '0, 1'b0, rdy, 1'b0);
    step(1'b0, 1'b1, r,  1'b0, rdy, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1; go = 1'b0; finish = 1'b0; range = '0; error = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // Reset values
    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(posedge clock);
    #1;

    // Basic session: busy for 4 cycles, result visible after capture
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h42);
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Overflow: five captures into four slots, then drain
    do_reset();
    for (int i = 1; i <= 5; i++) session(16'(i), 1'b0);
    @(negedge clock);
    check("t2_drop", 32'(drop_count), 32'd1);
    check("t2_head", 32'(out_data), 32'd1);
    @(posedge clock);
    #1;
    repeat (6) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Push into full FIFO with a simultaneous pop
    do_reset();
    for (int i = 1; i <= 4; i++) session(16'(i + 16'h10), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("t3_drop", 32'(drop_count), 32'd0);
    @(posedge clock);
    #1;
    repeat (5) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Error edges and saturation
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("t4_err2", 32'(err_count), 32'd2);
    @(posedge clock);
    #1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clock);
    check("t4_err_sat", 32'(err_count), 32'd255);
    @(posedge clock);
    #1;

    // finish held after capture pushes only once; reset mid-session
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("t5_one_entry", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    session(16'h0077, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    do_reset();
    @(negedge clock);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_err", 32'(err_count), 32'd0);
    @(posedge clock);
    #1;

`ifdef RANGE_COLLECT_MAX_EN
    do_reset();
    session(16'd7, 1'b1);
    session(16'd3, 1'b1);
    session(16'd12, 1'b1);
    session(16'd5, 1'b1);
    @(negedge clock);
    check("t6_max", 32'(max_range), 32'd12);
    @(posedge clock);
    #1;
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic g, f, e, rdy, rs;
      logic [WIDTH-1:0] r;
      g   = ($urandom_range(0, 99) < 40);
      f   = ($urandom_range(0, 99) < 35);
      e   = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 25 : 75));
      rs  = ($urandom_range(0, 999) < 5);
      r   = WIDTH'($urandom);
      step(g, f, r, e, rdy, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
